drive_mode_controller: RTL and testbench

- Top-level sequencer for the car's driving state.
- Owns the architectural registers power, state and moving_state, and registers the selected mode FSM's next-state outputs each cycle. Mode FSMs are manual, semi-auto and auto.
- Also owns power-button long-press on/off, the driving-mode selection lock, inactivity auto-power-off and a mileage counter.
- Sits between the mode FSMs and the display/motor logic.

---
 rtl/drive_mode_controller_if.sv | 61 ++++++
 rtl/drive_mode_controller.sv | 203 ++++++++++++++++++++
 tb/tb_drive_mode_controller.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/drive_mode_controller_if.sv
// Bundle between the drive-mode controller, the mode FSMs / driver inputs and the display/motor side.
// master drives the driver and mode-FSM signals; slave is the controller that owns the architectural outputs.
interface drive_mode_controller_if #(
    parameter int MILE_W = 16
);
    logic              power_btn;
    logic [1:0]        mode_sel;
    logic              clutch;
    logic              brake;
    logic              throttle;
    logic              rgs;
    logic              left;
    logic              right;

    logic              man_next_power;
    logic              semi_next_power;
    logic              auto_next_power;
    logic [1:0]        man_next_state;
    logic [1:0]        semi_next_state;
    logic [1:0]        auto_next_state;
    logic [3:0]        man_next_moving_state;
    logic [3:0]        semi_next_moving_state;
    logic [3:0]        auto_next_moving_state;
    logic              man_left_light;
    logic              man_right_light;
    logic              semi_left_light;
    logic              semi_right_light;
    logic              auto_left_light;
    logic              auto_right_light;

    logic              power;
    logic [1:0]        state;
    logic [3:0]        moving_state;
    logic [1:0]        mode;
    logic              turn_left_light;
    logic              turn_right_light;
    logic              idle_warn;
    logic [MILE_W-1:0] mileage;

    modport master (
        output power_btn, mode_sel, clutch, brake, throttle, rgs, left, right,
               man_next_power, semi_next_power, auto_next_power,
               man_next_state, semi_next_state, auto_next_state,
               man_next_moving_state, semi_next_moving_state, auto_next_moving_state,
               man_left_light, man_right_light, semi_left_light, semi_right_light,
               auto_left_light, auto_right_light,
        input  power, state, moving_state, mode, turn_left_light, turn_right_light,
               idle_warn, mileage
    );

    modport slave (
        input  power_btn, mode_sel, clutch, brake, throttle, rgs, left, right,
               man_next_power, semi_next_power, auto_next_power,
               man_next_state, semi_next_state, auto_next_state,
               man_next_moving_state, semi_next_moving_state, auto_next_moving_state,
               man_left_light, man_right_light, semi_left_light, semi_right_light,
               auto_left_light, auto_right_light,
        output power, state, moving_state, mode, turn_left_light, turn_right_light,
               idle_warn, mileage
    );
endinterface

// File: rtl/drive_mode_controller.sv
// Top-level driving-state sequencer: registers the selected mode FSM's outputs and owns
// power long-press, mode-selection lock, inactivity auto-off and the mileage counter.
module drive_mode_controller #(
    parameter int POWER_HOLD   = 100000000,
    parameter int IDLE_TIMEOUT = 500000000,
    parameter int WARN_CYCLES  = 200000000,
    parameter int MILE_TICK    = 100000000,
    parameter int MILE_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    drive_mode_controller_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_NSTART = 2'b00,
        ST_START  = 2'b01,
        ST_MOVING = 2'b10
    } drive_state_e;

    localparam logic [3:0] NON_MOVING    = 4'b0000;
    localparam logic [1:0] MODE_RESERVED = 2'b11;

    localparam int HOLD_W = $clog2(POWER_HOLD + 1);
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam int TICK_W = $clog2(MILE_TICK + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(POWER_HOLD - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] WARN_START = IDLE_W'(IDLE_TIMEOUT - WARN_CYCLES);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(MILE_TICK - 1);

    logic              power_q,   power_d;
    drive_state_e      state_q,   state_d;
    logic [3:0]        moving_q,  moving_d;
    logic [1:0]        mode_q,    mode_d;
    logic              left_q,    left_d;
    logic              right_q,   right_d;
    logic              warn_q,    warn_d;
    logic [MILE_W-1:0] mileage_q, mileage_d;
    logic [HOLD_W-1:0] hold_q,    hold_d;
    logic              armed_q,   armed_d;
    logic [IDLE_W-1:0] idle_q,    idle_d;
    logic [TICK_W-1:0] tick_q,    tick_d;

    logic       toggle;
    logic       activity;
    logic       idle_inc;
    logic       timeout;
    logic       moving_tick;
    logic       sel_power;
    logic [1:0] sel_state;
    logic [3:0] sel_moving;
    logic       sel_left;
    logic       sel_right;

    assign activity = bus.clutch | bus.brake | bus.throttle | bus.rgs |
                      bus.left | bus.right | bus.power_btn;
    assign idle_inc    = power_q && (state_q != ST_MOVING) && !activity;
    assign timeout     = idle_inc && (idle_q == IDLE_LAST);
    assign moving_tick = power_q && (state_q == ST_MOVING) && (moving_q != NON_MOVING);

    always_comb begin
        sel_power  = bus.man_next_power;
        sel_state  = bus.man_next_state;
        sel_moving = bus.man_next_moving_state;
        sel_left   = bus.man_left_light;
        sel_right  = bus.man_right_light;
        case (mode_q)
            2'b01: begin
                sel_power  = bus.semi_next_power;
                sel_state  = bus.semi_next_state;
                sel_moving = bus.semi_next_moving_state;
                sel_left   = bus.semi_left_light;
                sel_right  = bus.semi_right_light;
            end
            2'b10: begin
                sel_power  = bus.auto_next_power;
                sel_state  = bus.auto_next_state;
                sel_moving = bus.auto_next_moving_state;
                sel_left   = bus.auto_left_light;
                sel_right  = bus.auto_right_light;
            end
            default: ;
        endcase
    end

    // Long press: one toggle per press; the button must be released before it can arm again.
    always_comb begin
        hold_d  = hold_q;
        armed_d = armed_q;
        toggle  = 1'b0;
        if (!bus.power_btn) begin
            hold_d  = '0;
            armed_d = 1'b1;
        end else if (armed_q) begin
            if (hold_q == HOLD_LAST) begin
                toggle  = 1'b1;
                hold_d  = '0;
                armed_d = 1'b0;
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
    end

    always_comb begin
        power_d   = power_q;
        state_d   = state_q;
        moving_d  = moving_q;
        mode_d    = mode_q;
        left_d    = left_q;
        right_d   = right_q;
        mileage_d = mileage_q;
        tick_d    = tick_q;
        if (!power_q) begin
            if (toggle) begin
                power_d  = 1'b1;
                state_d  = ST_NSTART;
                moving_d = NON_MOVING;
                left_d   = 1'b0;
                right_d  = 1'b0;
            end
        end else begin
            if (moving_tick) begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (mileage_q != '1) begin
                        mileage_d = mileage_q + MILE_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            if (toggle || timeout) begin
                power_d  = 1'b0;
                state_d  = ST_NSTART;
                moving_d = NON_MOVING;
                left_d   = 1'b0;
                right_d  = 1'b0;
            end else if ((state_q == ST_NSTART) && (bus.mode_sel != mode_q) &&
                         (bus.mode_sel != MODE_RESERVED)) begin
                mode_d   = bus.mode_sel;
                state_d  = ST_NSTART;
                moving_d = NON_MOVING;
                left_d   = 1'b0;
                right_d  = 1'b0;
            end else if (!sel_power) begin
                power_d  = 1'b0;
                state_d  = ST_NSTART;
                moving_d = NON_MOVING;
                left_d   = 1'b0;
                right_d  = 1'b0;
            end else begin
                state_d  = drive_state_e'(sel_state);
                moving_d = sel_moving;
                left_d   = sel_left;
                right_d  = sel_right;
            end
        end
        // Warning follows the count it will hold after this edge, so it drops together with power.
        idle_d = (power_d && idle_inc) ? idle_q + IDLE_W'(1) : '0;
        warn_d = power_d && (idle_d >= WARN_START);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            power_q   <= 1'b0;
            state_q   <= ST_NSTART;
            moving_q  <= NON_MOVING;
            mode_q    <= 2'b00;
            left_q    <= 1'b0;
            right_q   <= 1'b0;
            warn_q    <= 1'b0;
            mileage_q <= '0;
            hold_q    <= '0;
            armed_q   <= 1'b1;
            idle_q    <= '0;
            tick_q    <= '0;
        end else begin
            power_q   <= power_d;
            state_q   <= state_d;
            moving_q  <= moving_d;
            mode_q    <= mode_d;
            left_q    <= left_d;
            right_q   <= right_d;
            warn_q    <= warn_d;
            mileage_q <= mileage_d;
            hold_q    <= hold_d;
            armed_q   <= armed_d;
            idle_q    <= idle_d;
            tick_q    <= tick_d;
        end
    end

    assign bus.power            = power_q;
    assign bus.state            = state_q;
    assign bus.moving_state     = moving_q;
    assign bus.mode             = mode_q;
    assign bus.turn_left_light  = left_q;
    assign bus.turn_right_light = right_q;
    assign bus.idle_warn        = warn_q;
    assign bus.mileage          = mileage_q;
endmodule

// File: tb/tb_drive_mode_controller.sv
// Bench for drive_mode_controller with small timing parameters: directed scenarios plus
// randomized traffic, all compared against a cycle-level behavioural model of the rules.
module tb_drive_mode_controller;
    localparam int POWER_HOLD   = 4;
    localparam int IDLE_TIMEOUT = 20;
    localparam int WARN_CYCLES  = 5;
    localparam int MILE_TICK    = 3;
    localparam int MILE_W       = 2;
    localparam int MILE_MAX     = (1 << MILE_W) - 1;
    localparam int VEC_W        = 12 + MILE_W;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    drive_mode_controller_if #(.MILE_W(MILE_W)) dif ();

    drive_mode_controller #(
        .POWER_HOLD  (POWER_HOLD),
        .IDLE_TIMEOUT(IDLE_TIMEOUT),
        .WARN_CYCLES (WARN_CYCLES),
        .MILE_TICK   (MILE_TICK),
        .MILE_W      (MILE_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic        m_power;
    logic [1:0]  m_state;
    logic [3:0]  m_mov;
    logic [1:0]  m_mode;
    logic        m_ll;
    logic        m_rl;
    logic        m_warn;
    int          m_mileage;
    int          m_hold;
    logic        m_armed;
    int          m_idle;
    int          m_ticks;

    logic [VEC_W-1:0] dut_vec;
    logic [VEC_W-1:0] exp_vec;
    assign dut_vec = {dif.power, dif.state, dif.moving_state, dif.mode, dif.turn_left_light,
                      dif.turn_right_light, dif.idle_warn, dif.mileage};
    assign exp_vec = {m_power, m_state, m_mov, m_mode, m_ll, m_rl, m_warn, MILE_W'(m_mileage)};

    task automatic model_off();
        m_power = 1'b0;
        m_state = 2'b00;
        m_mov   = 4'b0000;
        m_ll    = 1'b0;
        m_rl    = 1'b0;
    endtask

    task automatic model_step();
        logic       toggle;
        logic       active;
        logic       was_on;
        logic       was_moving;
        logic       in_nstart;
        logic       f_pw;
        logic       f_ll;
        logic       f_rl;
        logic [1:0] f_st;
        logic [3:0] f_mv;
        int         idle_n;
        if (rst !== 1'b1) begin
            model_off();
            m_mode    = 2'b00;
            m_warn    = 1'b0;
            m_mileage = 0;
            m_hold    = 0;
            m_armed   = 1'b1;
            m_idle    = 0;
            m_ticks   = 0;
        end else begin
            toggle = 1'b0;
            if (!dif.power_btn) begin
                m_armed = 1'b1;
                m_hold  = 0;
            end else if (m_armed) begin
                m_hold++;
                if (m_hold == POWER_HOLD) begin
                    toggle  = 1'b1;
                    m_hold  = 0;
                    m_armed = 1'b0;
                end
            end
            active = dif.clutch | dif.brake | dif.throttle | dif.rgs | dif.left | dif.right |
                     dif.power_btn;
            was_on     = m_power;
            was_moving = (m_state == 2'b10);
            in_nstart  = (m_state == 2'b00);
            idle_n     = (was_on && !was_moving && !active) ? m_idle + 1 : 0;
            case (m_mode)
                2'b01:   begin f_pw = dif.semi_next_power; f_st = dif.semi_next_state;
                               f_mv = dif.semi_next_moving_state;
                               f_ll = dif.semi_left_light; f_rl = dif.semi_right_light; end
                2'b10:   begin f_pw = dif.auto_next_power; f_st = dif.auto_next_state;
                               f_mv = dif.auto_next_moving_state;
                               f_ll = dif.auto_left_light; f_rl = dif.auto_right_light; end
                default: begin f_pw = dif.man_next_power; f_st = dif.man_next_state;
                               f_mv = dif.man_next_moving_state;
                               f_ll = dif.man_left_light; f_rl = dif.man_right_light; end
            endcase
            if (!was_on) begin
                if (toggle) begin
                    model_off();
                    m_power = 1'b1;
                end
            end else begin
                if (was_moving && m_mov != 4'b0000) begin
                    m_ticks++;
                    if (m_ticks == MILE_TICK) begin
                        m_ticks = 0;
                        if (m_mileage < MILE_MAX) m_mileage++;
                    end
                end
                if (toggle || idle_n == IDLE_TIMEOUT) begin
                    model_off();
                end else if (in_nstart && dif.mode_sel != m_mode && dif.mode_sel != 2'b11) begin
                    model_off();
                    m_power = 1'b1;
                    m_mode  = dif.mode_sel;
                end else if (!f_pw) begin
                    model_off();
                end else begin
                    m_state = f_st;
                    m_mov   = f_mv;
                    m_ll    = f_ll;
                    m_rl    = f_rl;
                end
            end
            m_idle = m_power ? idle_n : 0;
            m_warn = m_power && (m_idle >= IDLE_TIMEOUT - WARN_CYCLES);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_defaults();
        dif.power_btn = 1'b0;
        dif.clutch = 1'b1; dif.brake = 1'b0; dif.throttle = 1'b0;
        dif.rgs = 1'b0; dif.left = 1'b0; dif.right = 1'b0;
        dif.man_next_power = 1'b1; dif.semi_next_power = 1'b1; dif.auto_next_power = 1'b1;
        dif.man_next_state = 2'b00; dif.semi_next_state = 2'b00; dif.auto_next_state = 2'b00;
        dif.man_next_moving_state = 4'b0000; dif.semi_next_moving_state = 4'b0000;
        dif.auto_next_moving_state = 4'b0000;
        dif.man_left_light = 1'b0; dif.man_right_light = 1'b0;
        dif.semi_left_light = 1'b0; dif.semi_right_light = 1'b0;
        dif.auto_left_light = 1'b0; dif.auto_right_light = 1'b0;
    endtask

    task automatic press();
        dif.power_btn = 1'b1;
        repeat (POWER_HOLD) tick();
        dif.power_btn = 1'b0;
        tick();
    endtask

    function automatic logic [3:0] rand_mov();
        case ($urandom_range(4))
            0:       return 4'b0000;
            1:       return 4'b0001;
            2:       return 4'b0010;
            3:       return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (dut_vec !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", dut_vec);
        end
        checks++;
        if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL reset_model: got %h expected %h", dut_vec, exp_vec);
        end
        rst = 1'b1;
    endtask

    task automatic test_power_button();
        dif.power_btn = 1'b1;
        repeat (3) tick();
        dif.power_btn = 1'b0;
        tick();
        checks++;
        if (dif.power !== 1'b0) begin
            errors++; $display("FAIL short_press_power: got %b expected 0", dif.power);
        end
        dif.power_btn = 1'b1;
        repeat (3) tick();
        checks++;
        if (dif.power !== 1'b0) begin
            errors++; $display("FAIL hold3_power: got %b expected 0", dif.power);
        end
        tick();
        checks++;
        if ({dif.power, dif.state} !== 3'b1_00) begin
            errors++; $display("FAIL hold4_power_state: got %b expected 100", {dif.power, dif.state});
        end
        repeat (10) tick();
        checks++;
        if (dif.power !== 1'b1 || dut_vec !== exp_vec) begin
            errors++; $display("FAIL held_past_toggle: got %h expected %h", dut_vec, exp_vec);
        end
        dif.power_btn = 1'b0;
        tick();
    endtask

    task automatic test_power_off_moving();
        dif.man_next_state = 2'b10;
        dif.man_next_moving_state = 4'b0001;
        dif.man_left_light = 1'b1;
        tick();
        checks++;
        if ({dif.state, dif.moving_state, dif.turn_left_light} !== 7'b10_0001_1) begin
            errors++; $display("FAIL moving_registered: got %h expected %h", dut_vec, exp_vec);
        end
        dif.power_btn = 1'b1;
        repeat (3) tick();
        checks++;
        if ({dif.power, dif.state} !== 3'b1_10) begin
            errors++; $display("FAIL moving_hold3: got %b expected 110", {dif.power, dif.state});
        end
        tick();
        checks++;
        if ({dif.power, dif.state, dif.moving_state, dif.turn_left_light, dif.turn_right_light} !== '0) begin
            errors++; $display("FAIL moving_press_off_image: got %h expected %h", dut_vec, exp_vec);
        end
        dif.power_btn = 1'b0;
        set_defaults();
        tick();
    endtask

    task automatic test_mode_change();
        press();
        checks++;
        if ({dif.power, dif.mode, dif.state} !== 5'b1_00_00) begin
            errors++; $display("FAIL mode_power_on: got %h expected %h", dut_vec, exp_vec);
        end
        dif.mode_sel = 2'b10;
        tick();
        checks++;
        if (dif.mode !== 2'b10) begin
            errors++; $display("FAIL mode_to_auto: got %b expected 10", dif.mode);
        end
        dif.auto_next_state = 2'b01;
        tick();
        dif.mode_sel = 2'b01;
        tick();
        checks++;
        if ({dif.mode, dif.state} !== 4'b10_01) begin
            errors++; $display("FAIL mode_locked_in_start: got %b expected 1001", {dif.mode, dif.state});
        end
        dif.mode_sel = 2'b10;
        dif.auto_next_state = 2'b00;
        tick();
        dif.mode_sel = 2'b11;
        tick();
        checks++;
        if ({dif.mode, dif.state} !== 4'b10_00) begin
            errors++; $display("FAIL mode_reserved_ignored: got %b expected 1000", {dif.mode, dif.state});
        end
        dif.mode_sel = 2'b00;
        tick();
        checks++;
        if (dif.mode !== 2'b00 || dut_vec !== exp_vec) begin
            errors++; $display("FAIL mode_back_manual: got %h expected %h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_idle();
        dif.clutch = 1'b0;
        repeat (14) tick();
        checks++;
        if ({dif.power, dif.idle_warn} !== 2'b10) begin
            errors++; $display("FAIL idle14_warn: got %b expected 10", {dif.power, dif.idle_warn});
        end
        tick();
        checks++;
        if ({dif.power, dif.idle_warn} !== 2'b11) begin
            errors++; $display("FAIL idle15_warn: got %b expected 11", {dif.power, dif.idle_warn});
        end
        repeat (3) tick();
        dif.brake = 1'b1;
        tick();
        dif.brake = 1'b0;
        checks++;
        if ({dif.power, dif.idle_warn} !== 2'b10) begin
            errors++; $display("FAIL brake_clears_warn: got %b expected 10", {dif.power, dif.idle_warn});
        end
        repeat (19) tick();
        checks++;
        if ({dif.power, dif.idle_warn} !== 2'b11) begin
            errors++; $display("FAIL idle19_still_on: got %b expected 11", {dif.power, dif.idle_warn});
        end
        tick();
        checks++;
        if ({dif.power, dif.idle_warn, dif.state} !== 4'b0000 || dut_vec !== exp_vec) begin
            errors++; $display("FAIL idle20_timeout: got %h expected %h", dut_vec, exp_vec);
        end
        dif.clutch = 1'b1;
        tick();
    endtask

    task automatic test_mileage();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        press();
        dif.man_next_state = 2'b10;
        dif.man_next_moving_state = 4'b0001;
        tick();
        repeat (8) tick();
        checks++;
        if (dif.mileage !== MILE_W'(2)) begin
            errors++; $display("FAIL mileage_after8: got %0d expected 2", dif.mileage);
        end
        tick();
        checks++;
        if (dif.mileage !== MILE_W'(3)) begin
            errors++; $display("FAIL mileage_after9: got %0d expected 3", dif.mileage);
        end
        repeat (6) tick();
        checks++;
        if (dif.mileage !== MILE_W'(3) || dut_vec !== exp_vec) begin
            errors++; $display("FAIL mileage_saturate: got %h expected %h", dut_vec, exp_vec);
        end
        set_defaults();
        tick();
        press();
        checks++;
        if ({dif.power, dif.mileage} !== {1'b0, MILE_W'(3)}) begin
            errors++; $display("FAIL mileage_power_off: got %h expected %h", dut_vec, exp_vec);
        end
        press();
        checks++;
        if ({dif.power, dif.mileage} !== {1'b1, MILE_W'(3)}) begin
            errors++; $display("FAIL mileage_power_on: got %h expected %h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_fsm_off_and_reset();
        dif.man_next_state = 2'b10;
        dif.man_next_moving_state = 4'b0001;
        dif.man_right_light = 1'b1;
        tick();
        dif.man_next_power = 1'b0;
        tick();
        checks++;
        if ({dif.power, dif.state, dif.moving_state, dif.turn_left_light, dif.turn_right_light} !== '0
            || dut_vec !== exp_vec) begin
            errors++; $display("FAIL fsm_power_off_image: got %h expected %h", dut_vec, exp_vec);
        end
        dif.man_next_power = 1'b1;
        press();
        tick();
        checks++;
        if ({dif.power, dif.state} !== 3'b1_10) begin
            errors++; $display("FAIL moving_before_reset: got %h expected %h", dut_vec, exp_vec);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (dut_vec !== '0) begin
            errors++; $display("FAIL reset_while_moving: got %h expected 0", dut_vec);
        end
        rst = 1'b1;
        set_defaults();
        tick();
    endtask

    task automatic test_random();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7) == 0) dif.power_btn = ~dif.power_btn;
            if ($urandom_range(7) == 0)
                {dif.clutch, dif.brake, dif.throttle, dif.rgs, dif.left, dif.right} = 6'($urandom);
            else
                {dif.clutch, dif.brake, dif.throttle, dif.rgs, dif.left, dif.right} = 6'b0;
            if ($urandom_range(15) == 0) dif.mode_sel = 2'($urandom);
            dif.man_next_power  = ($urandom_range(31) != 0);
            dif.semi_next_power = ($urandom_range(31) != 0);
            dif.auto_next_power = ($urandom_range(31) != 0);
            dif.man_next_state  = 2'($urandom_range(2));
            dif.semi_next_state = 2'($urandom_range(2));
            dif.auto_next_state = 2'($urandom_range(2));
            dif.man_next_moving_state  = rand_mov();
            dif.semi_next_moving_state = rand_mov();
            dif.auto_next_moving_state = rand_mov();
            {dif.man_left_light, dif.man_right_light, dif.semi_left_light,
             dif.semi_right_light, dif.auto_left_light, dif.auto_right_light} = 6'($urandom);
            rst = ($urandom_range(299) != 0);
            tick();
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL random_cycle_%0d: got %h expected %h", i, dut_vec, exp_vec);
            end
        end
        rst = 1'b1;
        set_defaults();
        dif.mode_sel = 2'b00;
    endtask

    initial begin
        rst = 1'b0;
        dif.mode_sel = 2'b00;
        set_defaults();
        test_reset();
        test_power_button();
        test_power_off_moving();
        test_mode_change();
        test_idle();
        test_mileage();
        test_fsm_off_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
